queue_ptr_table: RTL and testbench

- Owns a 2^IDX_WIDTH x 32 true-dual-port BRAM holding per-queue ring pointers.
- Port A is the owner end of the BRAM config interface (addr/wr_data/rd_en/wr_en in, rd_data out), driven by the PCIe register/JTAG user side.
- Port B serves a pipelined read-modify-write update stream: the packet-queue path advances a queue's tail by a packet size in flits and receives the old and new pointers.
- Sits between the packet-descriptor builder and the PCIe DMA writer.

---
 rtl/queue_ptr_table.sv | 189 ++++++++++++++++++
 tb/tb_queue_ptr_table.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_ptr_table.sv
// Per-queue ring pointer table: config port A plus a pipelined read-modify-write
// advance port B with writeback forwarding and a credit-protected result FIFO.
module queue_ptr_table #(
  parameter int IDX_WIDTH  = 10,
  parameter int RING_WIDTH = 16,
  parameter int SIZE_WIDTH = 11,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_WIDTH-1:0]  cfg_addr,
  input  logic [31:0]           cfg_wr_data,
  input  logic                  cfg_rd_en,
  input  logic                  cfg_wr_en,
  output logic [31:0]           cfg_rd_data,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [IDX_WIDTH-1:0]  upd_idx,
  input  logic [SIZE_WIDTH-1:0] upd_size,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_WIDTH-1:0]  out_idx,
  output logic [RING_WIDTH-1:0] out_old_ptr,
  output logic [RING_WIDTH-1:0] out_new_ptr
);
  localparam int DEPTH = 1 << IDX_WIDTH;
  localparam int PW    = $clog2(OUT_DEPTH);
  localparam int CW    = PW + 1;

  typedef struct packed {
    logic                  v;
    logic [IDX_WIDTH-1:0]  idx;
    logic [RING_WIDTH-1:0] val;
  } fwd_t;

  typedef struct packed {
    logic [IDX_WIDTH-1:0]  idx;
    logic [RING_WIDTH-1:0] old_ptr;
    logic [RING_WIDTH-1:0] new_ptr;
  } res_t;

  logic [31:0]           mem_q [DEPTH];
  logic [31:0]           cfg_raw_q;
  logic [RING_WIDTH-1:0] b_rd1_q, b_rd2_q;
  res_t                  fifo_q [OUT_DEPTH];

  logic                  cfg_rd_pend_q, cfg_rd_pend_d;
  logic [31:0]           cfg_rd_data_q, cfg_rd_data_d;
  logic                  s1_v_q, s1_v_d, s2_v_q, s2_v_d, s3_v_q, s3_v_d;
  logic [IDX_WIDTH-1:0]  s1_idx_q, s1_idx_d, s2_idx_q, s2_idx_d, s3_idx_q, s3_idx_d;
  logic [SIZE_WIDTH-1:0] s1_size_q, s1_size_d, s2_size_q, s2_size_d, s3_size_q, s3_size_d;
  logic                  s2_ovr_q, s2_ovr_d, s3_ovr_q, s3_ovr_d, s3_late_q, s3_late_d;
  logic [RING_WIDTH-1:0] s2_ovr_val_q, s2_ovr_val_d, s3_ovr_val_q, s3_ovr_val_d;
  fwd_t                  fwd_q [3];
  fwd_t                  fwd_d [3];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic                  upd_fire, out_fire, s3_wb_drop;
  logic [RING_WIDTH-1:0] cfg_val, s3_old, s3_new;
  logic [CW-1:0]         in_flight;
  logic [CW:0]           credit_used;
  res_t                  head;

  always_comb begin
    cfg_val    = cfg_wr_data[RING_WIDTH-1:0];
    in_flight  = CW'(s1_v_q) + CW'(s2_v_q) + CW'(s3_v_q);
    credit_used = {1'b0, count_q} + (CW+1)'(in_flight);
    upd_ready  = credit_used < (CW+1)'(OUT_DEPTH);
    upd_fire   = upd_valid && upd_ready;
    out_valid  = count_q != '0;
    out_fire   = out_valid && out_ready;
    s3_wb_drop = cfg_wr_en && (cfg_addr == s3_idx_q);

    // Youngest source wins; a late (S2) override is younger than fwd[1] but older than fwd[0].
    if (fwd_q[0].v && fwd_q[0].idx == s3_idx_q)      s3_old = fwd_q[0].val;
    else if (s3_ovr_q && s3_late_q)                   s3_old = s3_ovr_val_q;
    else if (fwd_q[1].v && fwd_q[1].idx == s3_idx_q) s3_old = fwd_q[1].val;
    else if (s3_ovr_q)                                s3_old = s3_ovr_val_q;
    else if (fwd_q[2].v && fwd_q[2].idx == s3_idx_q) s3_old = fwd_q[2].val;
    else                                              s3_old = b_rd2_q;
    s3_new = s3_old + RING_WIDTH'(s3_size_q);

    s1_v_d    = upd_fire;
    s1_idx_d  = upd_idx;
    s1_size_d = upd_size;

    s2_v_d       = s1_v_q;
    s2_idx_d     = s1_idx_q;
    s2_size_d    = s1_size_q;
    s2_ovr_d     = cfg_wr_en && (cfg_addr == s1_idx_q);
    s2_ovr_val_d = cfg_val;

    s3_v_d    = s2_v_q;
    s3_idx_d  = s2_idx_q;
    s3_size_d = s2_size_q;
    if (cfg_wr_en && (cfg_addr == s2_idx_q)) begin
      s3_ovr_d     = 1'b1;
      s3_late_d    = 1'b1;
      s3_ovr_val_d = cfg_val;
    end else begin
      s3_ovr_d     = s2_ovr_q;
      s3_late_d    = 1'b0;
      s3_ovr_val_d = s2_ovr_val_q;
    end

    fwd_d[0].v   = s3_v_q;
    fwd_d[0].idx = s3_idx_q;
    fwd_d[0].val = s3_wb_drop ? cfg_val : s3_new;
    for (int k = 1; k < 3; k++) begin
      fwd_d[k] = fwd_q[k-1];
      if (cfg_wr_en && fwd_q[k-1].idx == cfg_addr) fwd_d[k].val = cfg_val;
    end

    cfg_rd_pend_d = cfg_rd_en;
    cfg_rd_data_d = cfg_rd_pend_q ? cfg_raw_q : cfg_rd_data_q;

    wr_ptr_d = s3_v_q   ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = out_fire ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (s3_v_q && !out_fire)      count_d = count_q + CW'(1);
    else if (!s3_v_q && out_fire) count_d = count_q - CW'(1);

    head        = fifo_q[rd_ptr_q];
    out_idx     = out_valid ? head.idx     : '0;
    out_old_ptr = out_valid ? head.old_ptr : '0;
    out_new_ptr = out_valid ? head.new_ptr : '0;
    cfg_rd_data = cfg_rd_data_q;
  end

  // Table storage is left uninitialised by reset; software programs it.
  always_ff @(posedge clk) begin
    if (cfg_rd_en) cfg_raw_q <= mem_q[cfg_addr];
    b_rd1_q <= mem_q[s1_idx_q][RING_WIDTH-1:0];
    b_rd2_q <= b_rd1_q;
    if (s3_v_q && !s3_wb_drop) mem_q[s3_idx_q] <= 32'(s3_new);
    if (cfg_wr_en) mem_q[cfg_addr] <= cfg_wr_data;
  end

  always_ff @(posedge clk) begin
    if (s3_v_q) fifo_q[wr_ptr_q] <= '{idx: s3_idx_q, old_ptr: s3_old, new_ptr: s3_new};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_rd_pend_q <= 1'b0;
      cfg_rd_data_q <= '0;
      s1_v_q        <= 1'b0;
      s2_v_q        <= 1'b0;
      s3_v_q        <= 1'b0;
      s1_idx_q      <= '0;
      s2_idx_q      <= '0;
      s3_idx_q      <= '0;
      s1_size_q     <= '0;
      s2_size_q     <= '0;
      s3_size_q     <= '0;
      s2_ovr_q      <= 1'b0;
      s3_ovr_q      <= 1'b0;
      s3_late_q     <= 1'b0;
      s2_ovr_val_q  <= '0;
      s3_ovr_val_q  <= '0;
      for (int k = 0; k < 3; k++) fwd_q[k] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      cfg_rd_pend_q <= cfg_rd_pend_d;
      cfg_rd_data_q <= cfg_rd_data_d;
      s1_v_q        <= s1_v_d;
      s2_v_q        <= s2_v_d;
      s3_v_q        <= s3_v_d;
      s1_idx_q      <= s1_idx_d;
      s2_idx_q      <= s2_idx_d;
      s3_idx_q      <= s3_idx_d;
      s1_size_q     <= s1_size_d;
      s2_size_q     <= s2_size_d;
      s3_size_q     <= s3_size_d;
      s2_ovr_q      <= s2_ovr_d;
      s3_ovr_q      <= s3_ovr_d;
      s3_late_q     <= s3_late_d;
      s2_ovr_val_q  <= s2_ovr_val_d;
      s3_ovr_val_q  <= s3_ovr_val_d;
      for (int k = 0; k < 3; k++) fwd_q[k] <= fwd_d[k];
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end
endmodule

// File: tb/tb_queue_ptr_table.sv
// Randomised and directed bench for queue_ptr_table against an in-order
// sequential pointer-table model.
`timescale 1ns/1ps
module tb_queue_ptr_table;
  localparam int IW = 10;
  localparam int RW = 16;
  localparam int SW = 11;
  localparam int OD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] cfg_addr;
  logic [31:0]   cfg_wr_data;
  logic          cfg_rd_en;
  logic          cfg_wr_en;
  logic [31:0]   cfg_rd_data;
  logic          upd_valid;
  logic          upd_ready;
  logic [IW-1:0] upd_idx;
  logic [SW-1:0] upd_size;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic [RW-1:0] out_old_ptr;
  logic [RW-1:0] out_new_ptr;

  queue_ptr_table #(.IDX_WIDTH(IW), .RING_WIDTH(RW), .SIZE_WIDTH(SW), .OUT_DEPTH(OD)) dut (
    .clk(clk), .rst(rst),
    .cfg_addr(cfg_addr), .cfg_wr_data(cfg_wr_data), .cfg_rd_en(cfg_rd_en),
    .cfg_wr_en(cfg_wr_en), .cfg_rd_data(cfg_rd_data),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_idx(upd_idx), .upd_size(upd_size),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_old_ptr(out_old_ptr), .out_new_ptr(out_new_ptr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned idx;
    int unsigned old_p;
    int unsigned new_p;
    int unsigned cyc;
  } res_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  bit          last_acc;
  logic [31:0] model_mem [1 << IW];
  res_t        exp_q[$];
  res_t        got_q[$];

  // One clock: observe handshakes mid-cycle, then advance to just after the edge.
  task automatic step();
    res_t        r;
    int unsigned o;
    @(negedge clk);
    last_acc = upd_valid && upd_ready;
    if (out_valid && out_ready) begin
      r.idx = 32'(out_idx); r.old_p = 32'(out_old_ptr); r.new_p = 32'(out_new_ptr); r.cyc = cyc;
      got_q.push_back(r);
    end
    if (last_acc) begin
      o = 32'(model_mem[upd_idx][RW-1:0]);
      r.idx = 32'(upd_idx); r.old_p = o; r.new_p = (o + 32'(upd_size)) % (1 << RW); r.cyc = 0;
      exp_q.push_back(r);
      model_mem[upd_idx] = r.new_p;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cfg_write(input int idx, input logic [31:0] data);
    cfg_addr = IW'(idx); cfg_wr_data = data; cfg_wr_en = 1'b1;
    step();
    cfg_wr_en = 1'b0;
    model_mem[idx] = data;
  endtask

  task automatic cfg_read(input int idx, output logic [31:0] data);
    cfg_addr = IW'(idx); cfg_rd_en = 1'b1;
    step();
    cfg_rd_en = 1'b0;
    step();
    data = cfg_rd_data;
  endtask

  task automatic run_update(input int idx, input int size);
    int n = 0;
    upd_idx = IW'(idx); upd_size = SW'(size); upd_valid = 1'b1;
    do begin step(); n++; end while (!last_acc && n < 50);
    upd_valid = 1'b0;
    checks++;
    if (!last_acc) begin errors++; $display("FAIL update_accept_timeout: idx %0d not accepted in %0d cycles", idx, n); end
  endtask

  task automatic drain(input int n);
    int k = 0;
    while (got_q.size() < n && k < 100) begin step(); k++; end
    checks++;
    if (got_q.size() < n) begin errors++; $display("FAIL drain_timeout: got %0d results, expected %0d", got_q.size(), n); end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_addr = '0; cfg_wr_data = '0; cfg_rd_en = 1'b0; cfg_wr_en = 1'b0;
    upd_valid = 1'b0; upd_idx = '0; upd_size = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL reset_upd_ready: got %0b expected 1", upd_ready); end
    checks++; if (cfg_rd_data !== 32'h0) begin errors++; $display("FAIL reset_cfg_rd_data: got %h expected 0", cfg_rd_data); end
    checks++;
    if (out_idx !== '0 || out_old_ptr !== '0 || out_new_ptr !== '0) begin
      errors++; $display("FAIL reset_out_fields: got idx %0d old %h new %h expected all 0", out_idx, out_old_ptr, out_new_ptr);
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    int lat = 0;
    cfg_write(5, 32'h0000_0100);
    cfg_read(5, rd);
    checks++; if (rd !== 32'h100) begin errors++; $display("FAIL basic_cfg_read: got %h expected 00000100", rd); end
    got_q.delete(); exp_q.delete();
    upd_idx = 10'd5; upd_size = 11'd8; upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    checks++; if (!last_acc) begin errors++; $display("FAIL basic_accept: update not accepted"); end
    while (got_q.size() == 0 && lat < 20) begin step(); lat++; end
    checks++; if (lat != 4) begin errors++; $display("FAIL basic_latency: got %0d cycles expected 4", lat); end
    checks++;
    if (got_q.size() == 0 || got_q[0].idx != 5 || got_q[0].old_p != 32'h100 || got_q[0].new_p != 32'h108) begin
      errors++; $display("FAIL basic_result: got %0d results (first idx/old/new %0d/%h/%h) expected 5/0100/0108",
                         got_q.size(), got_q.size() ? got_q[0].idx : 0, got_q.size() ? got_q[0].old_p : 0, got_q.size() ? got_q[0].new_p : 0);
    end
    cfg_addr = 10'd5; cfg_rd_en = 1'b1;
    step();
    cfg_rd_en = 1'b0;
    checks++; if (cfg_rd_data !== 32'h100) begin errors++; $display("FAIL basic_rd_hold: got %h one cycle after strobe, expected previous 00000100", cfg_rd_data); end
    step();
    checks++; if (cfg_rd_data !== 32'h108) begin errors++; $display("FAIL basic_rd_latency: got %h two cycles after strobe, expected 00000108", cfg_rd_data); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int acc = 0;
    cfg_write(7, 32'h0);
    got_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      upd_idx = 10'd7; upd_size = 11'd1; upd_valid = 1'b1;
      step();
      if (last_acc) acc++;
    end
    upd_valid = 1'b0;
    checks++; if (acc != 4) begin errors++; $display("FAIL b2b_accepts: got %0d accepted expected 4", acc); end
    drain(4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].old_p != i || got_q[i].new_p != i + 1 || got_q[i].cyc != got_q[0].cyc + i) begin
        errors++; $display("FAIL b2b_result[%0d]: got old %0d new %0d cyc+%0d expected old %0d new %0d cyc+%0d",
                           i, got_q[i].old_p, got_q[i].new_p, got_q[i].cyc - got_q[0].cyc, i, i + 1, i);
      end
    end
    cfg_read(7, rd);
    checks++; if (rd !== 32'h4) begin errors++; $display("FAIL b2b_table: got %h expected 00000004", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    cfg_write(3, 32'hABCD_FFFE);
    got_q.delete(); exp_q.delete();
    run_update(3, 3);
    drain(1);
    checks++;
    if (got_q.size() < 1 || got_q[0].old_p != 32'hFFFE || got_q[0].new_p != 32'h1) begin
      errors++; $display("FAIL wrap_result: got old %h new %h expected fffe/0001",
                         got_q.size() ? got_q[0].old_p : 0, got_q.size() ? got_q[0].new_p : 0);
    end
    cfg_read(3, rd);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL wrap_table: got %h expected 00000001", rd); end
    got_q.delete(); exp_q.delete();
    run_update(3, 0);
    drain(1);
    checks++;
    if (got_q.size() < 1 || got_q[0].old_p != 1 || got_q[0].new_p != 1) begin
      errors++; $display("FAIL size0_result: got old %h new %h expected 0001/0001",
                         got_q.size() ? got_q[0].old_p : 0, got_q.size() ? got_q[0].new_p : 0);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int k = 0;
    logic [IW-1:0] h_idx;
    logic [RW-1:0] h_old, h_new;
    cfg_write(20, 32'h200);
    got_q.delete(); exp_q.delete();
    out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      upd_idx = 10'd20; upd_size = SW'(acc + 1); upd_valid = 1'b1;
      step();
      if (last_acc) acc++;
    end
    checks++; if (acc != 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", acc); end
    checks++; if (upd_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %0b expected 0", upd_ready); end
    h_idx = out_idx; h_old = out_old_ptr; h_new = out_new_ptr;
    checks++;
    if (out_valid !== 1'b1 || h_old !== 16'h200 || h_new !== 16'h201) begin
      errors++; $display("FAIL bp_head: got valid %0b old %h new %h expected 1/0200/0201", out_valid, h_old, h_new);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      if (last_acc) acc++;
      checks++;
      if (out_idx !== h_idx || out_old_ptr !== h_old || out_new_ptr !== h_new) begin
        errors++; $display("FAIL bp_stable: got %0d/%h/%h expected %0d/%h/%h", out_idx, out_old_ptr, out_new_ptr, h_idx, h_old, h_new);
      end
    end
    out_ready = 1'b1;
    while (acc < 6 && k < 50) begin
      upd_idx = 10'd20; upd_size = SW'(acc + 1); upd_valid = 1'b1;
      step();
      if (last_acc) acc++;
      k++;
    end
    upd_valid = 1'b0;
    checks++; if (acc != 6) begin errors++; $display("FAIL bp_total_accepted: got %0d expected 6", acc); end
    drain(6);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d results expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].idx != exp_q[i].idx || got_q[i].old_p != exp_q[i].old_p || got_q[i].new_p != exp_q[i].new_p) begin
        errors++; $display("FAIL bp_order[%0d]: got %0d/%h/%h expected %0d/%h/%h", i, got_q[i].idx, got_q[i].old_p,
                           got_q[i].new_p, exp_q[i].idx, exp_q[i].old_p, exp_q[i].new_p);
      end
    end
  endtask

  task automatic test_cfg_collision();
    logic [31:0] rd;
    // cfg write lands while the update sits in S2: new old value is the cfg data
    cfg_write(9, 32'h10);
    got_q.delete(); exp_q.delete();
    run_update(9, 2);
    step();
    cfg_addr = 10'd9; cfg_wr_data = 32'h50; cfg_wr_en = 1'b1;
    step();
    cfg_wr_en = 1'b0;
    drain(1);
    checks++;
    if (got_q.size() < 1 || got_q[0].old_p != 32'h50 || got_q[0].new_p != 32'h52) begin
      errors++; $display("FAIL s2_collision_result: got old %h new %h expected 0050/0052",
                         got_q.size() ? got_q[0].old_p : 0, got_q.size() ? got_q[0].new_p : 0);
    end
    cfg_read(9, rd);
    checks++; if (rd !== 32'h52) begin errors++; $display("FAIL s2_collision_table: got %h expected 00000052", rd); end
    model_mem[9] = 32'h52;
    // cfg write in the same cycle as the S3 writeback: cfg wins the table, result uses prior value
    cfg_write(11, 32'h30);
    got_q.delete(); exp_q.delete();
    run_update(11, 4);
    step();
    step();
    cfg_addr = 10'd11; cfg_wr_data = 32'h70; cfg_wr_en = 1'b1;
    step();
    cfg_wr_en = 1'b0;
    drain(1);
    checks++;
    if (got_q.size() < 1 || got_q[0].old_p != 32'h30 || got_q[0].new_p != 32'h34) begin
      errors++; $display("FAIL s3_collision_result: got old %h new %h expected 0030/0034",
                         got_q.size() ? got_q[0].old_p : 0, got_q.size() ? got_q[0].new_p : 0);
    end
    cfg_read(11, rd);
    checks++; if (rd !== 32'h70) begin errors++; $display("FAIL s3_collision_table: got %h expected 00000070", rd); end
    model_mem[11] = 32'h70;
  endtask

  task automatic test_reset_midstream();
    logic [31:0] rd;
    for (int k = 0; k < 4; k++) cfg_write(30 + k, 32'h1000 + k);
    got_q.delete(); exp_q.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      upd_idx = IW'(30 + k); upd_size = 11'd5; upd_valid = 1'b1;
      step();
    end
    upd_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %0b expected 1", out_valid); end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_idx !== '0 || out_old_ptr !== '0 || out_new_ptr !== '0 || cfg_rd_data !== 32'h0) begin
      errors++; $display("FAIL midrst_async_clear: got valid %0b idx %0d old %h new %h rd %h expected all 0",
                         out_valid, out_idx, out_old_ptr, out_new_ptr, cfg_rd_data);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %0b expected 1", upd_ready); end
    out_ready = 1'b1;
    got_q.delete(); exp_q.delete();
    repeat (6) step();
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL midrst_no_output: got %0d results expected 0", got_q.size()); end
    cfg_read(30, rd);
    checks++; if (rd !== 32'h1005) begin errors++; $display("FAIL midrst_done_entry: got %h expected 00001005", rd); end
    for (int k = 1; k < 4; k++) begin
      cfg_read(30 + k, rd);
      model_mem[30 + k] = 32'h1000 + k;
      checks++; if (rd !== 32'h1000 + k) begin errors++; $display("FAIL midrst_unchanged[%0d]: got %h expected %h", 30 + k, rd, 32'h1000 + k); end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    for (int k = 0; k < 8; k++) cfg_write(40 + k, $urandom());
    got_q.delete(); exp_q.delete();
    for (int c = 0; c < 300; c++) begin
      upd_valid = ($urandom_range(0, 9) < 7);
      upd_idx   = IW'(40 + $urandom_range(0, 7));
      upd_size  = ($urandom_range(0, 7) == 0) ? SW'(0) : SW'($urandom_range(0, 2047));
      out_ready = ($urandom_range(0, 9) < 6);
      step();
    end
    upd_valid = 1'b0;
    out_ready = 1'b1;
    drain(exp_q.size());
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d results expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].idx != exp_q[i].idx || got_q[i].old_p != exp_q[i].old_p || got_q[i].new_p != exp_q[i].new_p) begin
        errors++; $display("FAIL rand_result[%0d]: got %0d/%h/%h expected %0d/%h/%h", i, got_q[i].idx, got_q[i].old_p,
                           got_q[i].new_p, exp_q[i].idx, exp_q[i].old_p, exp_q[i].new_p);
      end
    end
    for (int k = 0; k < 8; k++) begin
      cfg_read(40 + k, rd);
      checks++; if (rd !== model_mem[40 + k]) begin errors++; $display("FAIL rand_table[%0d]: got %h expected %h", 40 + k, rd, model_mem[40 + k]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_wrap();
    test_backpressure();
    test_cfg_collision();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
